// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path (and the matching transmitter).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int CHAR_BITS = 7;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase reset by clr.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_char_rx.sv
// 8N1 serial receiver feeding the 7-bit character display; optional even parity
// bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_char_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [CHAR_BITS-1:0] char,
    output logic                 char_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_t            state, state_nxt;
    logic                 sync1, rx_s;
    logic                 tick;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 half_pt, full_pt;
    logic                 good, ferr;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, perr;
`endif

    // Tick phase restarts at the start edge so every sample lands mid-bit.
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .tick  (tick)
    );

    assign half_pt = tick && (scnt == HALF_LAST);
    assign full_pt = tick && (scnt == FULL_LAST);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        good      = 1'b0;
        ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr      = 1'b0;
`endif
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: if (half_pt) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (full_pt && bcnt == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                       state_nxt = PARITY;
            PARITY: if (full_pt) state_nxt = STOP;
`else
                       state_nxt = STOP;
`endif
            STOP: if (full_pt) begin
                if (rx_s) begin
                    state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                    good = !par_bad;
                    perr = par_bad;
`else
                    good = 1'b1;
`endif
                end else begin
                    state_nxt = BREAK;
                    ferr      = 1'b1;
                end
            end
            BREAK: if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            scnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            char       <= '0;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync1      <= rx;
            rx_s       <= sync1;
            state      <= state_nxt;
            char_valid <= good;
            frame_err  <= ferr;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr;
`endif
            if (good)
                char <= shreg[CHAR_BITS-1:0];

            if (state == IDLE || (state == START && half_pt))
                scnt <= '0;
            else if (tick)
                scnt <= (scnt == FULL_LAST) ? '0 : scnt + 1'b1;

            if (state == IDLE)
                bcnt <= '0;
            else if (state == DATA && full_pt)
                bcnt <= bcnt + 1'b1;

            // LSB arrives first, so shift in from the top.
            if (state == DATA && full_pt)
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};

`ifdef UART_RX_PARITY_EN
            if (state == IDLE)
                par_bad <= 1'b0;
            else if (state == PARITY && full_pt)
                par_bad <= rx_s ^ (^shreg);
`endif
        end
    end

endmodule

// File: tb/tb_uart_char_rx.sv
// Directed bench for uart_char_rx: a frame-level expectation queue drives a per-cycle
// compare of the output pulses and char; directed checks pin latency and timing.
module tb_uart_char_rx;
    localparam int DIV     = 27;
    localparam int OS      = 16;
    localparam int BIT_CLK = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME   = 11;
`else
    localparam int FRAME   = 10;
`endif
    // 2 sync flops + 1 cycle to leave IDLE, then half a bit plus the remaining bits.
    localparam int LAT = 3 + DIV * (OS / 2 + OS * (FRAME - 1));

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [6:0] char;
    logic       char_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
`endif

    uart_char_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .char       (char),
        .char_valid (char_valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected output events: kind 0 = good char, 1 = framing error, 2 = parity error.
    typedef struct {
        int         cyc;
        int         kind;
        logic [6:0] ch;
    } ev_t;
    ev_t q[$];

    logic [6:0] model_char = 7'h0;
    int   n_valid = 0, n_ferr = 0, n_perr = 0;
    int   last_v_cyc = 0, prev_v_cyc = 0, busy_fall = 0;
    logic busy_d = 1'b0;

    always @(negedge clk) begin
        logic ev_v, ev_f, ev_p;
        if (rst_n) begin
            ev_v = 1'b0; ev_f = 1'b0; ev_p = 1'b0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                case (q[0].kind)
                    0: begin ev_v = 1'b1; model_char = q[0].ch; end
                    1: ev_f = 1'b1;
                    default: ev_p = 1'b1;
                endcase
                void'(q.pop_front());
            end
            check("char_valid", char_valid, ev_v);
            check("frame_err", frame_err, ev_f);
            check("char", char, model_char);
`ifdef UART_RX_PARITY_EN
            check("parity_err", parity_err, ev_p);
            if (parity_err) n_perr++;
`endif
            if (char_valid) begin prev_v_cyc = last_v_cyc; last_v_cyc = cyc; n_valid++; end
            if (frame_err) n_ferr++;
            if (busy_d && !busy) busy_fall = cyc;
            busy_d = busy;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Called half a cycle after... actually #1 after an edge; returns aligned the same way.
    task automatic bit_out(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int k);
        ev_t e;
        k = cyc;
        e.cyc = k + LAT;
        e.ch  = b[6:0];
`ifdef UART_RX_PARITY_EN
        e.kind = !stop ? 1 : (par_flip ? 2 : 0);
`else
        e.kind = !stop ? 1 : 0;
`endif
        q.push_back(e);
        bit_out(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) bit_out(b[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
        bit_out((^b) ^ par_flip, BIT_CLK);
`endif
        bit_out(stop, BIT_CLK);
    endtask

    initial begin
        int k, h;
        logic [7:0] b5a;
        repeat (3) @(posedge clk);
        #1;
        check("reset char", char, 7'h0);
        check("reset char_valid", char_valid, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        bit_out(1'b1, BIT_CLK);

        // 0x41: one good character, fixed latency, busy drops at the stop midpoint
        send_frame(8'h41, 1'b1, k);
        bit_out(1'b1, BIT_CLK);
        check("t1 char", char, 7'h41);
        check("t1 n_valid", n_valid, 1);
`ifdef UART_RX_PARITY_EN
        check("t1 latency", last_v_cyc - k, 4539);
        check("t1 busy fall", busy_fall - k, 4539);
`else
        check("t1 latency", last_v_cyc - k, 4107);
        check("t1 busy fall", busy_fall - k, 4107);
`endif

        // 100-clk glitch rejected
        bit_out(1'b0, 100);
        h = cyc;
        bit_out(1'b1, 2 * BIT_CLK);
        check("t2 busy fall window", (busy_fall > h) && (busy_fall - h <= 216), 1'b1);
        check("t2 n_valid", n_valid, 1);
        check("t2 n_ferr", n_ferr, 0);

        // 0x55 with low stop bit, line held low, then 0x31
        send_frame(8'h55, 1'b0, k);
        bit_out(1'b0, 2000);
        bit_out(1'b1, BIT_CLK);
        check("t3 n_ferr", n_ferr, 1);
        check("t3 char kept", char, 7'h41);
        check("t3 n_valid", n_valid, 1);
        send_frame(8'h31, 1'b1, k);
        bit_out(1'b1, BIT_CLK);
        check("t3 char 31", char, 7'h31);
        check("t3 n_valid after", n_valid, 2);
        check("t3 n_ferr after", n_ferr, 1);

        // bit 7 set is silently dropped
        send_frame(8'hC1, 1'b1, k);
        bit_out(1'b1, BIT_CLK);
        check("t4 char", char, 7'h41);
        check("t4 n_valid", n_valid, 3);
        check("t4 n_ferr", n_ferr, 1);

        // back-to-back frames, no idle gap
        send_frame(8'h30, 1'b1, k);
        send_frame(8'h39, 1'b1, k);
        bit_out(1'b1, BIT_CLK);
        check("t5 char", char, 7'h39);
        check("t5 n_valid", n_valid, 5);
`ifdef UART_RX_PARITY_EN
        check("t5 spacing", last_v_cyc - prev_v_cyc, 4752);
`else
        check("t5 spacing", last_v_cyc - prev_v_cyc, 4320);
`endif

        // reset in the middle of data bit 4 of 0x5A
        b5a = 8'h5A;
        bit_out(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) bit_out(b5a[i], BIT_CLK);
        bit_out(b5a[4], BIT_CLK / 2);
        check("t6 busy before reset", busy, 1'b1);
        rst_n = 1'b0;
        q.delete();
        model_char = 7'h0;
        #1;
        check("t6 reset char", char, 7'h0);
        check("t6 reset char_valid", char_valid, 1'b0);
        check("t6 reset frame_err", frame_err, 1'b0);
        check("t6 reset busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bit_out(1'b1, BIT_CLK);
        check("t6 n_valid", n_valid, 5);
        send_frame(8'h42, 1'b1, k);
        bit_out(1'b1, BIT_CLK);
        check("t7 char", char, 7'h42);
        check("t7 n_valid", n_valid, 6);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h42, 1'b1, k);
        par_flip = 1'b0;
        bit_out(1'b1, BIT_CLK);
        check("t8 n_perr", n_perr, 1);
        check("t8 char kept", char, 7'h42);
        check("t8 n_valid", n_valid, 6);
`endif

        check("pending events", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
